// File: rtl/cam_table_controller.sv
// MAC-to-port table with serialised learn/lookup access, one entry searched per cycle.
// Define CAM_AGING_EN to enable per-entry aging driven by age_tick.
module cam_table_controller #(
   parameter int unsigned NUMBER_OF_ENTRIES = 16,
   parameter int unsigned PORT_WIDTH        = 4,
   localparam int unsigned IW               = $clog2(NUMBER_OF_ENTRIES)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  learn_request,
   input  logic [47:0]           learn_mac,
   input  logic [PORT_WIDTH-1:0] learn_port,
   output logic                  learn_ack,
   input  logic                  lookup_request,
   input  logic [47:0]           lookup_mac,
   output logic                  lookup_ack,
   output logic                  lookup_hit,
   output logic [PORT_WIDTH-1:0] lookup_port,
   input  logic                  age_tick,
   output logic [IW:0]           entry_count
);
   localparam int unsigned N = NUMBER_OF_ENTRIES;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP_SCAN, S_LEARN_SCAN, S_LEARN_COMMIT, S_AGE} state_t;

   state_t                state_q, state_d;
   logic                  valid_q [N];
   logic [47:0]           mac_q [N];
   logic [PORT_WIDTH-1:0] port_q [N];
   logic [IW-1:0]         index_q, rp_q, match_idx_q, free_idx_q;
   logic                  match_found_q, free_found_q, last_served_q;
   logic [47:0]           op_mac_q;
   logic [PORT_WIDTH-1:0] op_port_q;
   logic                  learn_ack_q, lookup_ack_q, lookup_hit_q;
   logic [PORT_WIDTH-1:0] lookup_port_q;
   logic [IW:0]           entry_count_q;

   logic                  tick_pending;
   logic [N-1:0]          expire;
   logic [IW:0]           aged_out;
   logic                  grant_lookup, grant_learn, lookup_ok, learn_ok;
   logic                  entry_match, last_index, op_multicast, scan_hit, lookup_done;
   logic [IW-1:0]         commit_idx;
   logic                  commit_new, commit_store;

   assign entry_match  = valid_q[index_q] && (mac_q[index_q] == op_mac_q);
   assign last_index   = (index_q == IW'(N - 1));
   assign op_multicast = op_mac_q[40];
   assign scan_hit     = !op_multicast && entry_match;
   assign lookup_done  = (state_q == S_LOOKUP_SCAN) && (op_multicast || entry_match || last_index);
   // Existing entry first, then lowest free slot, else round-robin victim.
   assign commit_idx   = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : rp_q);
   assign commit_new   = !match_found_q && free_found_q;
   assign commit_store = !op_multicast;

   always_comb begin
      state_d      = state_q;
      grant_lookup = 1'b0;
      grant_learn  = 1'b0;
      // A requester still seeing its ack has not yet had the chance to drop its request.
      lookup_ok    = lookup_request && !lookup_ack_q;
      learn_ok     = learn_request && !learn_ack_q;
      unique case (state_q)
         S_IDLE: begin
            if (tick_pending) begin
               state_d = S_AGE;
            end else if (lookup_ok && (!learn_ok || last_served_q)) begin
               grant_lookup = 1'b1;
               state_d      = S_LOOKUP_SCAN;
            end else if (learn_ok) begin
               grant_learn = 1'b1;
               state_d     = S_LEARN_SCAN;
            end
         end
         S_LOOKUP_SCAN:  if (lookup_done) state_d = S_IDLE;
         S_LEARN_SCAN:   if (last_index) state_d = S_LEARN_COMMIT;
         S_LEARN_COMMIT: state_d = S_IDLE;
         S_AGE:          state_d = S_IDLE;
         default:        state_d = S_IDLE;
      endcase
   end

`ifdef CAM_AGING_EN
   logic [1:0] age_q [N];
   logic       tick_pending_q;

   assign tick_pending = tick_pending_q;

   always_comb begin
      expire   = '0;
      aged_out = '0;
      for (int i = 0; i < N; i++) begin
         expire[i] = (state_q == S_AGE) && valid_q[i] && (age_q[i] == 2'd3);
         if (expire[i]) aged_out = aged_out + (IW + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tick_pending_q <= 1'b0;
         for (int i = 0; i < N; i++) age_q[i] <= 2'd0;
      end else begin
         // A tick seen while one is already pending merges into it.
         if (state_q == S_IDLE && tick_pending_q) tick_pending_q <= 1'b0;
         else if (age_tick) tick_pending_q <= 1'b1;
         if (state_q == S_AGE) begin
            for (int i = 0; i < N; i++) begin
               if (valid_q[i] && age_q[i] != 2'd3) age_q[i] <= age_q[i] + 2'd1;
            end
         end
         if (state_q == S_LOOKUP_SCAN && scan_hit) age_q[index_q] <= 2'd0;
         if (state_q == S_LEARN_COMMIT && commit_store) age_q[commit_idx] <= 2'd0;
      end
   end
`else
   logic unused_age_tick;
   assign unused_age_tick = age_tick;
   assign tick_pending    = 1'b0;
   assign expire          = '0;
   assign aged_out        = '0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         index_q       <= '0;
         rp_q          <= '0;
         match_idx_q   <= '0;
         free_idx_q    <= '0;
         match_found_q <= 1'b0;
         free_found_q  <= 1'b0;
         last_served_q <= 1'b1;
         op_mac_q      <= '0;
         op_port_q     <= '0;
         learn_ack_q   <= 1'b0;
         lookup_ack_q  <= 1'b0;
         lookup_hit_q  <= 1'b0;
         lookup_port_q <= '0;
         entry_count_q <= '0;
         for (int i = 0; i < N; i++) begin
            valid_q[i] <= 1'b0;
            mac_q[i]   <= '0;
            port_q[i]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         learn_ack_q  <= 1'b0;
         lookup_ack_q <= 1'b0;
         if (grant_lookup || grant_learn) begin
            index_q       <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            last_served_q <= grant_learn;
            op_mac_q      <= grant_learn ? learn_mac : lookup_mac;
            op_port_q     <= learn_port;
         end
         if (state_q == S_LOOKUP_SCAN || state_q == S_LEARN_SCAN) index_q <= index_q + IW'(1);
         if (state_q == S_LEARN_SCAN) begin
            if (!match_found_q && entry_match) begin
               match_found_q <= 1'b1;
               match_idx_q   <= index_q;
            end
            if (!free_found_q && !valid_q[index_q]) begin
               free_found_q <= 1'b1;
               free_idx_q   <= index_q;
            end
         end
         if (lookup_done) begin
            lookup_ack_q  <= 1'b1;
            lookup_hit_q  <= scan_hit;
            lookup_port_q <= scan_hit ? port_q[index_q] : '0;
         end
         if (state_q == S_LEARN_COMMIT) begin
            learn_ack_q <= 1'b1;
            if (commit_store) begin
               valid_q[commit_idx] <= 1'b1;
               mac_q[commit_idx]   <= op_mac_q;
               port_q[commit_idx]  <= op_port_q;
               if (!match_found_q && !free_found_q) rp_q <= rp_q + IW'(1);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (expire[i]) valid_q[i] <= 1'b0;
         end
         if (state_q == S_LEARN_COMMIT && commit_store && commit_new) begin
            entry_count_q <= entry_count_q + (IW + 1)'(1);
         end else if (state_q == S_AGE) begin
            entry_count_q <= entry_count_q - aged_out;
         end
      end
   end

   assign learn_ack   = learn_ack_q;
   assign lookup_ack  = lookup_ack_q;
   assign lookup_hit  = lookup_hit_q;
   assign lookup_port = lookup_port_q;
   assign entry_count = entry_count_q;

endmodule

// File: tb/tb_cam_table_controller.sv
// Randomised bench for cam_table_controller against an array-based table model.
module tb_cam_table_controller;
   localparam int unsigned N  = 16;
   localparam int unsigned PW = 4;
   localparam int unsigned IW = $clog2(N);

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          learn_request = 1'b0, lookup_request = 1'b0, age_tick = 1'b0;
   logic [47:0]   learn_mac = '0, lookup_mac = '0;
   logic [PW-1:0] learn_port = '0;
   logic          learn_ack, lookup_ack, lookup_hit;
   logic [PW-1:0] lookup_port;
   logic [IW:0]   entry_count;

   cam_table_controller #(.NUMBER_OF_ENTRIES(N), .PORT_WIDTH(PW)) dut (
      .clock(clock), .reset_n(reset_n),
      .learn_request(learn_request), .learn_mac(learn_mac), .learn_port(learn_port),
      .learn_ack(learn_ack),
      .lookup_request(lookup_request), .lookup_mac(lookup_mac), .lookup_ack(lookup_ack),
      .lookup_hit(lookup_hit), .lookup_port(lookup_port),
      .age_tick(age_tick), .entry_count(entry_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic check_value(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Reference table: plain arrays, lowest index wins, round-robin victim when full.
   logic          m_valid [N];
   logic [47:0]   m_mac [N];
   logic [PW-1:0] m_port [N];
   int            m_age [N];
   int            m_rp, m_count;
   logic          m_hit;
   logic [PW-1:0] m_lport;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_mac[i] = '0; m_port[i] = '0; m_age[i] = 0;
      end
      m_rp = 0; m_count = 0; m_hit = 1'b0; m_lport = '0;
   endfunction

   function automatic int model_lookup(input logic [47:0] mac);
      m_hit = 1'b0;
      m_lport = '0;
      if (mac[40]) return 1;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && m_mac[i] == mac) begin
            m_hit = 1'b1; m_lport = m_port[i]; m_age[i] = 0;
            return i + 1;
         end
      end
      return N;
   endfunction

   function automatic void model_learn(input logic [47:0] mac, input logic [PW-1:0] port);
      if (mac[40]) return;
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && m_mac[i] == mac) begin
            m_port[i] = port; m_age[i] = 0;
            return;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!m_valid[i]) begin
            m_valid[i] = 1'b1; m_mac[i] = mac; m_port[i] = port; m_age[i] = 0; m_count++;
            return;
         end
      end
      m_mac[m_rp] = mac; m_port[m_rp] = port; m_age[m_rp] = 0;
      m_rp = (m_rp + 1) % N;
   endfunction

   function automatic void model_tick();
      for (int i = 0; i < N; i++) begin
         if (m_valid[i]) begin
            if (m_age[i] == 3) begin
               m_valid[i] = 1'b0; m_count--;
            end else begin
               m_age[i]++;
            end
         end
      end
   endfunction

   task automatic do_reset();
      reset_n = 1'b0; learn_request = 1'b0; lookup_request = 1'b0; age_tick = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      model_reset();
      check_value("rst_acks", 64'({learn_ack, lookup_ack}), 64'd0);
      check_value("rst_hit", 64'(lookup_hit), 64'd0);
      check_value("rst_port", 64'(lookup_port), 64'd0);
      check_value("rst_count", 64'(entry_count), 64'd0);
   endtask

   // Counts edges from acceptance (edge 0) until an ack is seen.
   task automatic wait_ack(input int start, output bit gl, output bit gn, output int cyc);
      cyc = start; gl = 1'b0; gn = 1'b0;
      while (!gl && !gn && cyc < 200) begin
         @(posedge clock); #1;
         cyc++;
         gl = lookup_ack; gn = learn_ack;
      end
      if (!gl && !gn) check_value("ack_timeout", 64'({lookup_ack, learn_ack}), 64'd1);
   endtask

   task automatic do_lookup(input string tag, input logic [47:0] mac);
      int exp_lat, cyc;
      bit gl, gn;
      exp_lat = model_lookup(mac);
      lookup_mac = mac; lookup_request = 1'b1;
      wait_ack(-1, gl, gn, cyc);
      lookup_request = 1'b0;
      check_value({tag, "_ack"}, 64'({gl, gn}), 64'd2);
      check_value({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check_value({tag, "_hit"}, 64'(lookup_hit), 64'(m_hit));
      check_value({tag, "_port"}, 64'(lookup_port), 64'(m_lport));
      check_value({tag, "_count"}, 64'(entry_count), 64'(m_count));
      @(posedge clock); #1;
      check_value({tag, "_pulse"}, 64'(lookup_ack), 64'd0);
   endtask

   task automatic do_learn(input string tag, input logic [47:0] mac, input logic [PW-1:0] port,
                           input bit tick_mid);
      int cyc;
      bit gl, gn;
      learn_mac = mac; learn_port = port; learn_request = 1'b1;
      if (tick_mid) begin
         @(posedge clock); #1 age_tick = 1'b1;
         @(posedge clock); #1 age_tick = 1'b0;
         wait_ack(1, gl, gn, cyc);
      end else begin
         wait_ack(-1, gl, gn, cyc);
      end
      learn_request = 1'b0;
      model_learn(mac, port);
      if (tick_mid) model_tick();
      check_value({tag, "_ack"}, 64'({gl, gn}), 64'd1);
      check_value({tag, "_lat"}, 64'(cyc), 64'(N + 1));
      check_value({tag, "_hold_hit"}, 64'(lookup_hit), 64'(m_hit));
      check_value({tag, "_hold_port"}, 64'(lookup_port), 64'(m_lport));
      @(posedge clock); #1;
      check_value({tag, "_pulse"}, 64'(learn_ack), 64'd0);
      if (tick_mid) repeat (2) @(posedge clock);
      #0 check_value({tag, "_count"}, 64'(entry_count), 64'(m_count));
   endtask

   task automatic do_tick();
      age_tick = 1'b1;
      @(posedge clock); #1 age_tick = 1'b0;
      repeat (3) @(posedge clock);
      #1 model_tick();
      check_value("tick_count", 64'(entry_count), 64'(m_count));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [47:0] mac;
      int exp_lat, cyc, r;
      bit gl, gn, exp_lookup;

      do_reset();
      do_lookup("empty", 48'h00_11_22_33_44_55);
      do_learn("learn1", 48'h00_11_22_33_44_55, 4'd3, 1'b0);
      do_lookup("hit1", 48'h00_11_22_33_44_55);
      do_lookup("bcast", 48'hFF_FF_FF_FF_FF_FF);
      do_learn("learn_bc", 48'hFF_FF_FF_FF_FF_FF, 4'd7, 1'b0);

      do_reset();
      for (int i = 0; i < 17; i++) begin
         do_learn($sformatf("fill%0d", i), 48'h00_AA_00_00_00_00 + 48'(i), PW'(i % 16), 1'b0);
      end
      do_lookup("full_first", 48'h00_AA_00_00_00_00);
      do_lookup("full_last", 48'h00_AA_00_00_00_10);
      do_learn("full_18", 48'h00_AA_00_00_00_11, 4'd9, 1'b0);
      do_lookup("full_second", 48'h00_AA_00_00_00_01);

      // Both requesters held high: must alternate, lookup first.
      do_reset();
      mac = 48'h00_BB_00_00_00_01;
      lookup_mac = mac; learn_mac = mac; learn_port = 4'd5;
      lookup_request = 1'b1; learn_request = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_lookup = (k % 2 == 0);
         if (exp_lookup) exp_lat = model_lookup(mac);
         else begin
            model_learn(mac, 4'd5); exp_lat = N + 1;
         end
         wait_ack(-1, gl, gn, cyc);
         check_value($sformatf("arb%0d_order", k), 64'({gl, gn}), exp_lookup ? 64'd2 : 64'd1);
         check_value($sformatf("arb%0d_lat", k), 64'(cyc), 64'(exp_lat));
         check_value($sformatf("arb%0d_hit", k), 64'(lookup_hit), 64'(m_hit));
         check_value($sformatf("arb%0d_port", k), 64'(lookup_port), 64'(m_lport));
      end
      lookup_request = 1'b0; learn_request = 1'b0;
      repeat (2) @(posedge clock);
      #1;

`ifdef CAM_AGING_EN
      do_reset();
      mac = 48'h00_CC_00_00_00_01;
      do_learn("age_learn", mac, 4'd6, 1'b0);
      repeat (3) do_tick();
      do_lookup("age_3ticks", mac);
      repeat (4) do_tick();
      do_lookup("age_4ticks", mac);
      do_learn("age_defer", mac, 4'd2, 1'b1);
      repeat (3) do_tick();
      do_lookup("age_defer_look", mac);
`endif

      do_reset();
      for (int t = 0; t < 60; t++) begin
`ifdef CAM_AGING_EN
         r = int'($urandom_range(0, 10));
`else
         r = int'($urandom_range(0, 9));
`endif
         mac = 48'h02_00_00_00_00_00 + 48'($urandom_range(0, 23));
         if (r == 9) mac = 48'h01_00_5E_00_00_00 + 48'($urandom_range(0, 255));
         if (r == 10) do_tick();
         else if (r < 5 || (r == 9 && $urandom_range(0, 1) == 0))
            do_lookup($sformatf("rnd%0d_lk", t), mac);
         else
            do_learn($sformatf("rnd%0d_ln", t), mac, PW'($urandom_range(0, 15)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
